settings_bus_demux: RTL and testbench

SETTINGS_BUS_DEMUX -- requirements
Module: settings_bus_demux

---
 rtl/settings_bus_demux.sv | 106 ++++++++++
 tb/tb_settings_bus_demux.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/settings_bus_demux.sv
// Routes one settings-bus write stream to NUM_BUSES output buses through a single holding register.
// Optional macro SETTINGS_BUS_DEMUX_DROP_CNT_EN enables the unmapped-write drop counter.
module settings_bus_demux #(
  parameter int AWIDTH    = 8,
  parameter int DWIDTH    = 32,
  parameter int NUM_BUSES = 2,
  parameter int SEL_BITS  = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       in_set_stb,
  input  logic [AWIDTH-1:0]          in_set_addr,
  input  logic [DWIDTH-1:0]          in_set_data,
  output logic                       in_ready,
  output logic [NUM_BUSES-1:0]       out_set_stb,
  output logic [AWIDTH-SEL_BITS-1:0] out_set_addr,
  output logic [DWIDTH-1:0]          out_set_data,
  input  logic [NUM_BUSES-1:0]       out_ready,
  output logic [15:0]                drop_cnt
);

  localparam int OAW = AWIDTH - SEL_BITS;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                state;
  logic                  init_p1;
  logic [NUM_BUSES-1:0]  stb_p1;
  logic [OAW-1:0]        addr_p1;
  logic [DWIDTH-1:0]     data_p1;

  logic [SEL_BITS-1:0]   sel_p0;
  logic                  mapped_p0;
  logic [NUM_BUSES-1:0]  onehot_p0;
  logic                  hold_rdy;
  logic                  xfer_p0;

  // Stage 0: decode the incoming write
  assign sel_p0    = in_set_addr[AWIDTH-1 -: SEL_BITS];
  assign mapped_p0 = (32'(sel_p0) < NUM_BUSES);

  always_comb begin
    onehot_p0 = '0;
    for (int i = 0; i < NUM_BUSES; i++) begin
      onehot_p0[i] = (32'(sel_p0) == i);
    end
  end

  // stb_p1 is one-hot on the held port, so masking out_ready with it ignores other ports.
  assign hold_rdy = (state == FULL) && ((stb_p1 & out_ready) != '0);
  assign in_ready = init_p1 && !clear && ((state == EMPTY) || hold_rdy);
  assign xfer_p0  = in_set_stb && in_ready;

  // Stage 1: holding register presented on the output buses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= EMPTY;
      init_p1 <= 1'b0;
      stb_p1  <= '0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      init_p1 <= 1'b1;
      if (clear) begin
        state  <= EMPTY;
        stb_p1 <= '0;
      end else if (xfer_p0 && mapped_p0) begin
        state   <= FULL;
        stb_p1  <= onehot_p0;
        addr_p1 <= in_set_addr[OAW-1:0];
        data_p1 <= in_set_data;
      end else if (hold_rdy) begin
        state  <= EMPTY;
        stb_p1 <= '0;
      end
    end
  end

  assign out_set_stb  = stb_p1;
  assign out_set_addr = addr_p1;
  assign out_set_data = data_p1;

`ifdef SETTINGS_BUS_DEMUX_DROP_CNT_EN
  logic [15:0] drop_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q <= '0;
    end else if (clear) begin
      drop_q <= '0;
    end else if (xfer_p0 && !mapped_p0) begin
      drop_q <= sat_inc(drop_q);
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_settings_bus_demux.sv
// Scoreboard bench for settings_bus_demux: default 2-bus instance plus a 3-bus instance for unmapped writes.
module tb_settings_bus_demux;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_set_stb = 1'b0;
  logic [7:0]  in_set_addr = '0;
  logic [31:0] in_set_data = '0;
  logic        in_ready;
  logic [1:0]  out_set_stb;
  logic [6:0]  out_set_addr;
  logic [31:0] out_set_data;
  logic [1:0]  out_ready = 2'b11;
  logic [15:0] drop_cnt;

  logic        in_set_stb3 = 1'b0;
  logic [7:0]  in_set_addr3 = '0;
  logic [31:0] in_set_data3 = '0;
  logic        in_ready3;
  logic [2:0]  out_set_stb3;
  logic [5:0]  out_set_addr3;
  logic [31:0] out_set_data3;
  logic [2:0]  out_ready3 = 3'b111;
  logic [15:0] drop_cnt3;

`ifdef SETTINGS_BUS_DEMUX_DROP_CNT_EN
  localparam logic [15:0] EXP_DROP = 16'd3;
`else
  localparam logic [15:0] EXP_DROP = 16'd0;
`endif

  typedef struct {
    logic [1:0]  stb;
    logic [6:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int fails = 0;
  int delivered = 0;

  always #5 clk = ~clk;

  settings_bus_demux u_dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_set_stb(in_set_stb), .in_set_addr(in_set_addr), .in_set_data(in_set_data),
    .in_ready(in_ready), .out_set_stb(out_set_stb), .out_set_addr(out_set_addr),
    .out_set_data(out_set_data), .out_ready(out_ready), .drop_cnt(drop_cnt)
  );

  settings_bus_demux #(.AWIDTH(8), .DWIDTH(32), .NUM_BUSES(3), .SEL_BITS(2)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_set_stb(in_set_stb3), .in_set_addr(in_set_addr3), .in_set_data(in_set_data3),
    .in_ready(in_ready3), .out_set_stb(out_set_stb3), .out_set_addr(out_set_addr3),
    .out_set_data(out_set_data3), .out_ready(out_ready3), .drop_cnt(drop_cnt3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every handshake on the 2-bus instance must match the head of the queue.
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_set_stb != 2'b00 && (out_set_stb & out_ready) != 2'b00) begin
        checks++;
        delivered++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: stb=%b addr=%h data=%h, expected no write", out_set_stb, out_set_addr, out_set_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (out_set_stb !== e.stb || out_set_addr !== e.addr || out_set_data !== e.data) begin
            fails++;
            $display("FAIL write_order: got stb=%b addr=%h data=%h, expected stb=%b addr=%h data=%h",
                     out_set_stb, out_set_addr, out_set_data, e.stb, e.addr, e.data);
          end
        end
      end
      checks++;
      if (out_set_stb3 !== 3'b000) begin
        fails++;
        $display("FAIL unmapped_strobe: stb3=%b, expected 000", out_set_stb3);
      end
    end
  end

  // Call just after a posedge; returns just after the posedge on which the write transferred.
  task automatic write(input logic [7:0] a, input logic [31:0] d, input bit deliver, input bit must_accept);
    int n;
    exp_t e;
    in_set_stb  = 1'b1;
    in_set_addr = a;
    in_set_data = d;
    n = 0;
    @(negedge clk);
    if (must_accept) chk("in_ready_b2b", 32'(in_ready), 32'd1);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", n);
    end else if (deliver) begin
      e.stb  = a[7] ? 2'b10 : 2'b01;
      e.addr = a[6:0];
      e.data = d;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int cycles);
    in_set_stb = 1'b0;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    chk("rst_stb", 32'(out_set_stb), 32'd0);
    chk("rst_addr", 32'(out_set_addr), 32'd0);
    chk("rst_data", out_set_data, 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    #19 reset_n = 1'b1;
    #1 chk("in_ready_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("in_ready_after_edge", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Unmapped select on the 3-bus instance
    in_set_stb3  = 1'b1;
    in_set_addr3 = 8'hC0;
    in_set_data3 = 32'h1234_5678;
    repeat (3) begin
      @(negedge clk);
      chk("unmapped_in_ready", 32'(in_ready3), 32'd1);
      @(posedge clk); #1;
    end
    in_set_stb3 = 1'b0;
    @(negedge clk);
    chk("unmapped_drop_cnt", 32'(drop_cnt3), 32'(EXP_DROP));
    @(posedge clk); #1;

    // Single write to port 1
    out_ready = 2'b11;
    write(8'h85, 32'hDEAD_BEEF, 1'b1, 1'b1);
    idle(3);

    // Back-to-back writes to port 0 then port 1
    write(8'h01, 32'h1111_0001, 1'b1, 1'b1);
    write(8'h81, 32'h2222_0081, 1'b1, 1'b1);
    idle(3);

    // Stall port 0; second write must wait behind it
    out_ready = 2'b00;
    write(8'h01, 32'hAAAA_0001, 1'b1, 1'b1);
    in_set_stb  = 1'b1;
    in_set_addr = 8'h02;
    in_set_data = 32'hBBBB_0002;
    repeat (5) begin
      @(negedge clk);
      chk("stall_stb", 32'(out_set_stb), 32'h1);
      chk("stall_data", out_set_data, 32'hAAAA_0001);
      chk("stall_addr", 32'(out_set_addr), 32'h01);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 2'b01;
    write(8'h02, 32'hBBBB_0002, 1'b1, 1'b1);
    idle(3);

    // Clear while holding a stalled write
    out_ready = 2'b00;
    write(8'h81, 32'hCCCC_0081, 1'b0, 1'b1);
    idle(0);
    @(negedge clk);
    chk("pre_clear_stb", 32'(out_set_stb), 32'h2);
    @(posedge clk); #1;
    clear = 1'b1;
    in_set_stb  = 1'b1;
    in_set_addr = 8'h05;
    @(negedge clk);
    chk("clear_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0;
    in_set_stb = 1'b0;
    @(negedge clk);
    chk("post_clear_stb", 32'(out_set_stb), 32'd0);
    chk("post_clear_drop", 32'(drop_cnt), 32'd0);
    chk("post_clear_drop3", 32'(drop_cnt3), 32'd0);
    @(posedge clk); #1;
    out_ready = 2'b11;
    idle(3);

    // Reset in the middle of a stall
    out_ready = 2'b00;
    write(8'h01, 32'hDDDD_0001, 1'b0, 1'b1);
    idle(0);
    @(negedge clk);
    chk("pre_reset_stb", 32'(out_set_stb), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_reset_stb", 32'(out_set_stb), 32'd0);
    chk("mid_reset_addr", 32'(out_set_addr), 32'd0);
    chk("mid_reset_data", out_set_data, 32'd0);
    chk("mid_reset_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("post_reset_in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("post_reset_in_ready_high", 32'(in_ready), 32'd1);
    out_ready = 2'b11;
    @(posedge clk); #1;
    write(8'h02, 32'hEEEE_0002, 1'b1, 1'b1);
    idle(4);

    chk("delivered_count", 32'(delivered), 32'd6);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
